// File: rtl/coin_validator_if.sv
// Coin-path signal bundle between the coin validator and its environment.
// The slave modport is the validator's view; master drives the sensor and casher side.
interface coin_validator_if;
    logic       coin_sensor;
    logic       accept_en;
    logic       coin_reject;
    logic       coin_insert;
    logic [2:0] inserted_coin;
    logic       return_gate;
    logic       coin_jam;

    modport master (
        output coin_sensor,
        output accept_en,
        output coin_reject,
        input  coin_insert,
        input  inserted_coin,
        input  return_gate,
        input  coin_jam
    );

    modport slave (
        input  coin_sensor,
        input  accept_en,
        input  coin_reject,
        output coin_insert,
        output inserted_coin,
        output return_gate,
        output coin_jam
    );
endinterface

// File: rtl/coin_validator.sv
// Coin validator: synchronizes and debounces the chute sensor, measures the blocked
// pulse width, classifies the coin and either hands it to the casher or returns it.
module coin_validator #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYC     = 4,
    parameter int CNT_W       = 8,
    parameter int DIME_MIN    = 8,
    parameter int DIME_MAX    = 14,
    parameter int NICKEL_MIN  = 16,
    parameter int NICKEL_MAX  = 24,
    parameter int QUARTER_MIN = 28,
    parameter int QUARTER_MAX = 40,
    parameter int GATE_CYC    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    coin_validator_if.slave  bus
);

    localparam int DEB_W  = $clog2(DEB_CYC + 1);
    localparam int GATE_W = $clog2(GATE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [2:0] CODE_NONE    = 3'b000;
    localparam logic [2:0] CODE_NICKEL  = 3'b001;
    localparam logic [2:0] CODE_DIME    = 3'b010;
    localparam logic [2:0] CODE_QUARTER = 3'b011;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MEASURE  = 3'd1,
        CLASSIFY = 3'd2,
        EMIT     = 3'd3,
        RETURN   = 3'd4
    } state_t;

    // Map a measured width onto a coin code; a saturated width is never a coin.
    function automatic logic [2:0] classify_width(input logic [CNT_W-1:0] w);
        logic [2:0] code;
        if (w == CNT_MAX) begin
            code = CODE_NONE;
        end else if (w >= CNT_W'(DIME_MIN) && w <= CNT_W'(DIME_MAX)) begin
            code = CODE_DIME;
        end else if (w >= CNT_W'(NICKEL_MIN) && w <= CNT_W'(NICKEL_MAX)) begin
            code = CODE_NICKEL;
        end else if (w >= CNT_W'(QUARTER_MIN) && w <= CNT_W'(QUARTER_MAX)) begin
            code = CODE_QUARTER;
        end else begin
            code = CODE_NONE;
        end
        return code;
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic [DEB_W-1:0]       deb_cnt_r;
    logic                   deb_r;
    logic                   deb_prev_r;
    logic                   deb_rise_s;

    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_inc_s;
    logic [2:0]             code_s;
    logic [GATE_W-1:0]      gate_cnt_r;
    logic                   coin_insert_r;
    logic [2:0]             inserted_coin_r;
    logic                   return_gate_r;
    logic                   coin_jam_r;

    // Metastability synchronizer for the asynchronous sensor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], bus.coin_sensor};
        end
    end

    // Debouncer: flip the level only after DEB_CYC consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_r      <= 1'b0;
            deb_cnt_r  <= '0;
            deb_prev_r <= 1'b0;
        end else begin
            deb_prev_r <= deb_r;
            if (sync_r[SYNC_STAGES-1] == deb_r) begin
                deb_cnt_r <= '0;
            end else if (deb_cnt_r == DEB_W'(DEB_CYC - 1)) begin
                deb_r     <= ~deb_r;
                deb_cnt_r <= '0;
            end else begin
                deb_cnt_r <= deb_cnt_r + {{(DEB_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign deb_rise_s = deb_r & ~deb_prev_r;

    // Saturating width increment and window classification of the current width.
    always_comb begin
        cnt_inc_s = cnt_r;
        code_s    = classify_width(cnt_r);
        if (cnt_r == CNT_MAX) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Main coin FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            cnt_r           <= '0;
            gate_cnt_r      <= '0;
            coin_insert_r   <= 1'b0;
            inserted_coin_r <= CODE_NONE;
            return_gate_r   <= 1'b0;
            coin_jam_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    coin_insert_r <= 1'b0;
                    // A coin arriving together with a reject request takes priority.
                    if (deb_rise_s) begin
                        state_r <= MEASURE;
                        cnt_r   <= {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (bus.coin_reject) begin
                        state_r       <= RETURN;
                        gate_cnt_r    <= '0;
                        return_gate_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MEASURE: begin
                    if (deb_r) begin
                        cnt_r      <= cnt_inc_s;
                        coin_jam_r <= (cnt_inc_s == CNT_MAX);
                    end else begin
                        state_r    <= CLASSIFY;
                        coin_jam_r <= 1'b0;
                    end
                end
                CLASSIFY: begin
                    if ((code_s != CODE_NONE) && bus.accept_en) begin
                        state_r         <= EMIT;
                        inserted_coin_r <= code_s;
                        coin_insert_r   <= 1'b1;
                    end else begin
                        state_r       <= RETURN;
                        gate_cnt_r    <= '0;
                        return_gate_r <= 1'b1;
                    end
                end
                EMIT: begin
                    state_r       <= IDLE;
                    coin_insert_r <= 1'b0;
                    cnt_r         <= '0;
                end
                RETURN: begin
                    if (gate_cnt_r == GATE_W'(GATE_CYC - 1)) begin
                        state_r       <= IDLE;
                        return_gate_r <= 1'b0;
                        gate_cnt_r    <= '0;
                        cnt_r         <= '0;
                    end else begin
                        gate_cnt_r <= gate_cnt_r + {{(GATE_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    cnt_r         <= '0;
                    gate_cnt_r    <= '0;
                    coin_insert_r <= 1'b0;
                    return_gate_r <= 1'b0;
                    coin_jam_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.coin_insert   = coin_insert_r;
    assign bus.inserted_coin = inserted_coin_r;
    assign bus.return_gate   = return_gate_r;
    assign bus.coin_jam      = coin_jam_r;

endmodule

// File: tb/tb_coin_validator.sv
// Directed bench for coin_validator: pulses of known width on the raw sensor, with
// expected codes, strobe timing and gate durations worked out by hand.
module tb_coin_validator;

    logic clk;
    logic rst_n;

    coin_validator_if bus ();

    coin_validator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int cyc;
    int ins_cnt;
    int first_ins;
    int gate_hi;
    int jam_hi;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        cyc       = 0;
        ins_cnt   = 0;
        first_ins = 0;
        gate_hi   = 0;
        jam_hi    = 0;
    endtask

    // One clock: advance past the rising edge, then sample outputs on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (bus.coin_insert === 1'b1) begin
            ins_cnt++;
            if (first_ins == 0) first_ins = cyc;
        end
        if (bus.return_gate === 1'b1) gate_hi++;
        if (bus.coin_jam === 1'b1) jam_hi++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input int w);
        bus.coin_sensor = 1'b1;
        steps(w);
        bus.coin_sensor = 1'b0;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        bus.coin_sensor = 1'b0;
        bus.accept_en   = 1'b0;
        bus.coin_reject = 1'b0;
        clear_mon();

        // Reset with idle sensor
        steps(3);
        check("rst_insert", 32'(bus.coin_insert), 32'd0);
        check("rst_code",   32'(bus.inserted_coin), 32'd0);
        check("rst_gate",   32'(bus.return_gate), 32'd0);
        check("rst_jam",    32'(bus.coin_jam), 32'd0);
        rst_n         = 1'b1;
        bus.accept_en = 1'b1;
        steps(5);

        // 20-cycle nickel; strobe 8 clocks after the raw falling edge
        pulse(20);
        clear_mon();
        steps(40);
        check("nickel_count", 32'(ins_cnt), 32'd1);
        check("nickel_lat",   32'(first_ins), 32'd8);
        check("nickel_code",  32'(bus.inserted_coin), 32'd1);
        check("nickel_gate",  32'(gate_hi), 32'd0);

        // Glitch then a 10-cycle dime
        pulse(2);
        steps(6);
        pulse(10);
        clear_mon();
        steps(40);
        check("dime_count", 32'(ins_cnt), 32'd1);
        check("dime_lat",   32'(first_ins), 32'd8);
        check("dime_code",  32'(bus.inserted_coin), 32'd2);

        // 50-cycle pulse matches no window
        clear_mon();
        pulse(50);
        steps(40);
        check("wide_insert", 32'(ins_cnt), 32'd0);
        check("wide_gate",   32'(gate_hi), 32'd16);
        check("wide_code",   32'(bus.inserted_coin), 32'd2);

        // Quarter while the casher is not ready
        bus.accept_en = 1'b0;
        clear_mon();
        pulse(32);
        steps(40);
        check("noacc_insert", 32'(ins_cnt), 32'd0);
        check("noacc_gate",   32'(gate_hi), 32'd16);
        check("noacc_code",   32'(bus.inserted_coin), 32'd2);
        bus.accept_en = 1'b1;

        // Jam: jam spans deb-high cycles 256..300 plus the first deb-low cycle
        clear_mon();
        pulse(300);
        steps(40);
        check("jam_cycles", 32'(jam_hi), 32'd46);
        check("jam_end",    32'(bus.coin_jam), 32'd0);
        check("jam_gate",   32'(gate_hi), 32'd16);
        check("jam_insert", 32'(ins_cnt), 32'd0);

        // coin_reject in IDLE opens the gate
        clear_mon();
        bus.coin_reject = 1'b1;
        step();
        bus.coin_reject = 1'b0;
        steps(30);
        check("rej_idle_gate",   32'(gate_hi), 32'd16);
        check("rej_idle_insert", 32'(ins_cnt), 32'd0);

        // coin_reject during MEASURE is ignored; quarter still accepted
        clear_mon();
        bus.coin_sensor = 1'b1;
        steps(15);
        bus.coin_reject = 1'b1;
        step();
        bus.coin_reject = 1'b0;
        steps(14);
        bus.coin_sensor = 1'b0;
        steps(40);
        check("rej_meas_gate",  32'(gate_hi), 32'd0);
        check("rej_meas_count", 32'(ins_cnt), 32'd1);
        check("rej_meas_code",  32'(bus.inserted_coin), 32'd3);

        // Async reset mid-MEASURE discards the coin in flight
        clear_mon();
        bus.coin_sensor = 1'b1;
        steps(12);
        rst_n = 1'b0;
        #1;
        check("arst_code",   32'(bus.inserted_coin), 32'd0);
        check("arst_insert", 32'(bus.coin_insert), 32'd0);
        steps(2);
        rst_n           = 1'b1;
        bus.coin_sensor = 1'b0;
        clear_mon();
        steps(40);
        check("arst_after_insert", 32'(ins_cnt), 32'd0);
        check("arst_after_gate",   32'(gate_hi), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
